fco_align_fsm: RTL and testbench

- Frame-clock (FCO) word-alignment controller for one AD9252 ADC.
- Watches the deserialized FCO word from the FCO ISERDESE2.
- Issues single-cycle bitslip pulses until the word equals the expected frame pattern, then confirms the lock and asserts fco_aligned.
- fco_aligned is the gate that lets the downstream per-channel data alignment FSM start. After lock, the block monitors the FCO word and withdraws fco_aligned on sustained loss.

---
 rtl/fco_align_fsm.sv | 156 +++++++++++++++
 tb/tb_fco_align_fsm.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fco_align_fsm.sv
// Frame-clock word-alignment controller for one AD9252 ADC.
// Bitslips the FCO ISERDESE2 until the deserialized word matches the frame
// pattern, confirms the lock over a run of matching cycles, then raises
// fco_aligned. Sustained loss of the pattern while aligned restarts the search.
module fco_align_fsm #(
    parameter logic [13:0] FCO_PATTERN    = 14'h3F80,
    parameter int unsigned SETTLE_CYCLES  = 15,
    parameter int unsigned CONFIRM_CYCLES = 1024,
    parameter int unsigned MAX_SLIPS      = 14,
    parameter int unsigned LOSS_CYCLES    = 4
) (
    input  logic        clk_ref,
    input  logic        reset_n,
    input  logic [13:0] fco_pattern,
    input  logic        soft_start,
    output logic        fco_bitslip,
    output logic        fco_aligned,
    output logic        align_err,
    output logic [3:0]  slip_cnt,
    output logic [6:0]  fco_fsm
);

    // One-hot encoding doubles as the debug bus, LSB first.
    typedef enum logic [6:0] {
        StIdle    = 7'b0000001,
        StSettle  = 7'b0000010,
        StCheck   = 7'b0000100,
        StSlip    = 7'b0001000,
        StConfirm = 7'b0010000,
        StAligned = 7'b0100000,
        StFail    = 7'b1000000
    } state_e;

    localparam logic [7:0]  SettleLoad  = 8'(SETTLE_CYCLES);
    localparam logic [19:0] ConfirmLast = 20'(CONFIRM_CYCLES - 1);
    localparam logic [3:0]  MaxSlips    = 4'(MAX_SLIPS);
    localparam logic [7:0]  LossLast    = 8'(LOSS_CYCLES - 1);

    state_e      state_q, state_d;
    logic [7:0]  settle_q, settle_d;
    logic [19:0] match_q, match_d;
    logic [7:0]  loss_q, loss_d;
    logic [3:0]  slip_q, slip_d;
    logic        pat_match;

    assign pat_match = (fco_pattern == FCO_PATTERN);

    // Next-state and counter updates; soft_start overrides every transition.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        match_d  = match_q;
        loss_d   = loss_q;
        slip_d   = slip_q;

        case (state_q)
            StIdle: begin
                state_d  = StSettle;
                settle_d = SettleLoad;
            end
            StSettle: begin
                if (settle_q <= 8'd1) begin
                    settle_d = '0;
                    state_d  = StCheck;
                end else begin
                    settle_d = settle_q - 8'd1;
                end
            end
            StCheck: begin
                if (pat_match) begin
                    match_d = '0;
                    state_d = StConfirm;
                end else if (slip_q >= MaxSlips) begin
                    state_d = StFail;
                end else begin
                    state_d = StSlip;
                end
            end
            StSlip: begin
                // Saturate so the count can never pass MAX_SLIPS or wrap.
                if (slip_q < MaxSlips) begin
                    slip_d = slip_q + 4'd1;
                end
                settle_d = SettleLoad;
                state_d  = StSettle;
            end
            StConfirm: begin
                if (pat_match) begin
                    if (match_q >= ConfirmLast) begin
                        match_d = '0;
                        loss_d  = '0;
                        state_d = StAligned;
                    end else begin
                        match_d = match_q + 20'd1;
                    end
                end else begin
                    match_d = '0;
                    state_d = (slip_q >= MaxSlips) ? StFail : StSlip;
                end
            end
            StAligned: begin
                if (pat_match) begin
                    loss_d = '0;
                end else if (loss_q >= LossLast) begin
                    state_d = StIdle;
                end else begin
                    loss_d = loss_q + 8'd1;
                end
            end
            StFail: begin
                state_d = StFail;
            end
            default: begin
                // Non-one-hot state recovers through IDLE.
                state_d = StIdle;
            end
        endcase

        if (soft_start) begin
            state_d = StIdle;
        end

        // Every entry to IDLE starts a clean attempt.
        if (state_d == StIdle) begin
            settle_d = '0;
            match_d  = '0;
            loss_d   = '0;
            slip_d   = '0;
        end
    end

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge clk_ref) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            settle_q <= '0;
            match_q  <= '0;
            loss_q   <= '0;
            slip_q   <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            match_q  <= match_d;
            loss_q   <= loss_d;
            slip_q   <= slip_d;
        end
    end

    // Outputs are direct decodes of the one-hot state flops.
    assign fco_bitslip = (state_q == StSlip);
    assign fco_aligned = (state_q == StAligned);
    assign align_err   = (state_q == StFail);
    assign slip_cnt    = slip_q;
    assign fco_fsm     = state_q;

endmodule

// File: tb/tb_fco_align_fsm.sv
// Scoreboard bench for fco_align_fsm: stimulus pushes expected per-cycle
// snapshots and expected bitslip pulse cycles; a monitor compares them.
module tb_fco_align_fsm;

    typedef struct {
        int          cyc;
        logic [13:0] v;
        string       name;
    } exp_t;

    localparam logic [6:0] S_IDLE = 7'b0000001;
    localparam logic [6:0] S_SETL = 7'b0000010;
    localparam logic [6:0] S_CHK  = 7'b0000100;
    localparam logic [6:0] S_SLIP = 7'b0001000;
    localparam logic [6:0] S_CONF = 7'b0010000;
    localparam logic [6:0] S_ALGN = 7'b0100000;
    localparam logic [6:0] S_ERR  = 7'b1000000;

    logic        clk_ref = 1'b0;
    logic        reset_n = 1'b0;
    logic        soft_start = 1'b0;
    logic [13:0] fco_pattern;
    logic        fco_bitslip;
    logic        fco_aligned;
    logic        align_err;
    logic [3:0]  slip_cnt;
    logic [6:0]  fco_fsm;

    int          cyc;
    int          n_pass = 0;
    int          n_total = 0;
    exp_t        exp_q[$];
    int          pulse_q[$];

    // ISERDES model: word is base rotated left by rot; each bitslip steps rot down.
    logic [13:0] base = 14'h3F80;
    logic [13:0] inj = 14'h0;
    int unsigned init_rot = 0;
    int unsigned rot;
    logic        load_rot = 1'b1;

    function automatic logic [13:0] rotl(input logic [13:0] w, input int unsigned r);
        logic [27:0] d;
        d = {w, w} << r;
        return d[27:14];
    endfunction

    assign fco_pattern = rotl(base, rot) ^ inj;

    always @(posedge clk_ref) begin
        if (load_rot) rot <= init_rot;
        else if (fco_bitslip) rot <= (rot == 0) ? 13 : rot - 1;
    end

    always #5 clk_ref = ~clk_ref;

    // Cycle index: 0 is the cycle after the last edge that sampled reset_n low.
    always @(posedge clk_ref) begin
        if (!reset_n) cyc <= 0;
        else cyc <= cyc + 1;
    end

    fco_align_fsm #(
        .FCO_PATTERN   (14'h3F80),
        .SETTLE_CYCLES (15),
        .CONFIRM_CYCLES(16),
        .MAX_SLIPS     (14),
        .LOSS_CYCLES   (4)
    ) dut (
        .clk_ref    (clk_ref),
        .reset_n    (reset_n),
        .fco_pattern(fco_pattern),
        .soft_start (soft_start),
        .fco_bitslip(fco_bitslip),
        .fco_aligned(fco_aligned),
        .align_err  (align_err),
        .slip_cnt   (slip_cnt),
        .fco_fsm    (fco_fsm)
    );

    // Monitor: compares snapshots due this cycle and every bitslip pulse.
    always @(negedge clk_ref) begin
        logic [13:0] act;
        act = {fco_fsm, fco_bitslip, fco_aligned, align_err, slip_cnt};
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            n_total = n_total + 1;
            $display("FAIL %s: snapshot for cycle %0d never sampled (now cycle %0d)",
                     exp_q[0].name, exp_q[0].cyc, cyc);
            void'(exp_q.pop_front());
        end
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            n_total = n_total + 1;
            if (act === exp_q[0].v) n_pass = n_pass + 1;
            else $display("FAIL %s @cyc %0d: got fsm=%b bs=%b al=%b err=%b slip=%0d, expected fsm=%b bs=%b al=%b err=%b slip=%0d",
                          exp_q[0].name, cyc, act[13:7], act[6], act[5], act[4], act[3:0],
                          exp_q[0].v[13:7], exp_q[0].v[6], exp_q[0].v[5], exp_q[0].v[4],
                          exp_q[0].v[3:0]);
            void'(exp_q.pop_front());
        end
        if (fco_bitslip) begin
            n_total = n_total + 1;
            if (pulse_q.size() > 0 && pulse_q[0] == cyc) begin
                n_pass = n_pass + 1;
                void'(pulse_q.pop_front());
            end else begin
                $display("FAIL bitslip_pulse: got pulse at cycle %0d, expected next at %0d",
                         cyc, (pulse_q.size() > 0) ? pulse_q[0] : -1);
            end
        end else if (pulse_q.size() > 0 && pulse_q[0] <= cyc) begin
            n_total = n_total + 1;
            $display("FAIL bitslip_pulse: no pulse at cycle %0d, expected pulse there",
                     pulse_q[0]);
            void'(pulse_q.pop_front());
        end
    end

    task automatic exp_st(input int c, input logic [6:0] st, input logic [3:0] sc,
                          input string nm);
        exp_t e;
        e.cyc  = c;
        e.v    = {st, st == S_SLIP, st == S_ALGN, st == S_ERR, sc};
        e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic exp_pulses(input int first, input int n);
        for (int i = 0; i < n; i++) pulse_q.push_back(first + 17 * i);
    endtask

    task automatic wait_cyc(input int c);
        for (int i = 0; i < 5000 && cyc != c; i++) begin
            @(posedge clk_ref);
            #1;
        end
        if (cyc != c) begin
            $display("FAIL wait_cyc: cycle %0d not reached, stuck at %0d", c, cyc);
            $fatal(1, "bench timeout");
        end
    endtask

    task automatic start_test(input logic [13:0] b, input int unsigned r);
        reset_n    = 1'b0;
        soft_start = 1'b0;
        inj        = '0;
        base       = b;
        init_rot   = r;
        load_rot   = 1'b1;
        repeat (3) @(posedge clk_ref);
        #1;
        load_rot = 1'b0;
        reset_n  = 1'b1;
    endtask

    initial begin
        // 1: already aligned word, no slips.
        start_test(14'h3F80, 0);
        exp_st(0, S_IDLE, 0, "t1_reset_idle");
        exp_st(1, S_SETL, 0, "t1_settle_first");
        exp_st(15, S_SETL, 0, "t1_settle_last");
        exp_st(16, S_CHK, 0, "t1_check");
        exp_st(17, S_CONF, 0, "t1_confirm_first");
        exp_st(32, S_CONF, 0, "t1_confirm_last");
        exp_st(33, S_ALGN, 0, "t1_aligned");
        exp_st(40, S_ALGN, 0, "t1_aligned_hold");
        wait_cyc(42);

        // 2: rotated 5 bits, then 5: loss handling in ALIGNED.
        start_test(14'h3F80, 5);
        exp_pulses(17, 5);
        exp_st(16, S_CHK, 0, "t2_check0");
        exp_st(17, S_SLIP, 0, "t2_slip1");
        exp_st(18, S_SETL, 1, "t2_settle1");
        exp_st(34, S_SLIP, 1, "t2_slip2");
        exp_st(85, S_SLIP, 4, "t2_slip5");
        exp_st(86, S_SETL, 5, "t2_settle5");
        exp_st(101, S_CHK, 5, "t2_check_match");
        exp_st(117, S_CONF, 5, "t2_confirm_last");
        exp_st(118, S_ALGN, 5, "t2_aligned");
        exp_st(123, S_ALGN, 5, "t5_three_miss_hold");
        exp_st(124, S_ALGN, 5, "t5_after_match");
        exp_st(127, S_ALGN, 5, "t5_third_miss");
        exp_st(128, S_ALGN, 5, "t5_fourth_miss_cycle");
        exp_st(129, S_IDLE, 0, "t5_loss_idle");
        exp_st(130, S_SETL, 0, "t5_realign_settle");
        exp_st(145, S_CHK, 0, "t5_realign_check");
        exp_st(162, S_ALGN, 0, "t5_realigned");
        wait_cyc(120);
        inj = 14'h0001;
        wait_cyc(123);
        inj = '0;
        wait_cyc(125);
        inj = 14'h0001;
        wait_cyc(129);
        inj = '0;
        wait_cyc(165);

        // 3: never-matching word -> FAIL, then soft_start recovery.
        start_test(14'h1555, 0);
        exp_pulses(17, 14);
        exp_st(17, S_SLIP, 0, "t3_slip1");
        exp_st(238, S_SLIP, 13, "t3_slip14");
        exp_st(239, S_SETL, 14, "t3_settle_max");
        exp_st(254, S_CHK, 14, "t3_check_max");
        exp_st(255, S_ERR, 14, "t3_fail");
        exp_st(270, S_ERR, 14, "t3_fail_hold");
        exp_st(275, S_ERR, 14, "t3_fail_before_soft");
        exp_st(276, S_IDLE, 0, "t3_soft_idle");
        exp_st(277, S_SETL, 0, "t3_restart");
        wait_cyc(275);
        soft_start = 1'b1;
        wait_cyc(276);
        soft_start = 1'b0;
        wait_cyc(285);

        // 4: one mismatch on the 8th CONFIRM cycle forces a full re-search.
        start_test(14'h3F80, 0);
        exp_pulses(25, 14);
        exp_st(24, S_CONF, 0, "t4_confirm8");
        exp_st(25, S_SLIP, 0, "t4_slip_on_miss");
        exp_st(26, S_SETL, 1, "t4_slipcnt1");
        exp_st(41, S_CHK, 1, "t4_recheck");
        exp_st(262, S_CHK, 14, "t4_check_match_at_max");
        exp_st(263, S_CONF, 14, "t4_confirm_at_max");
        exp_st(279, S_ALGN, 14, "t4_aligned");
        wait_cyc(24);
        inj = 14'h0100;
        wait_cyc(25);
        inj = '0;
        wait_cyc(285);

        // 6: one-cycle reset during SETTLE before the 3rd slip.
        start_test(14'h3F80, 5);
        exp_pulses(17, 2);
        exp_st(34, S_SLIP, 1, "t6_slip2");
        exp_st(35, S_SETL, 2, "t6_settle2");
        exp_st(40, S_SETL, 2, "t6_before_reset");
        wait_cyc(40);
        reset_n = 1'b0;
        @(negedge clk_ref);
        #1;
        exp_pulses(17, 3);
        exp_st(0, S_IDLE, 0, "t6_reset_values");
        exp_st(1, S_SETL, 0, "t6_restart");
        exp_st(17, S_SLIP, 0, "t6_slip1_again");
        exp_st(18, S_SETL, 1, "t6_slipcnt1");
        exp_st(51, S_SLIP, 2, "t6_slip3");
        exp_st(52, S_SETL, 3, "t6_slipcnt3");
        exp_st(84, S_ALGN, 3, "t6_aligned");
        @(posedge clk_ref);
        #1;
        reset_n = 1'b1;
        wait_cyc(90);

        @(negedge clk_ref);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
